// File: rtl/dmx_rx_if.sv
// DMX512 receiver output bundle: slot RAM write port and frame status.
// The receiver drives master; the RAM/copy logic listens on slave.
interface dmx_rx_if;
    logic       wr_en;
    logic [9:0] wr_addr;
    logic [7:0] wr_data;
    logic [7:0] start_code;
    logic       frame_done;
    logic [9:0] slot_count;
    logic       framing_err;
    logic       busy;

    modport master (
        output wr_en, wr_addr, wr_data, start_code,
        output frame_done, slot_count, framing_err, busy
    );
    modport slave (
        input wr_en, wr_addr, wr_data, start_code,
        input frame_done, slot_count, framing_err, busy
    );
endinterface

// File: rtl/dmx_rx.sv
// DMX512 line receiver: BREAK/MAB detect, 8N2 deserialiser, slot RAM writer.
// Frames end on the zero byte the next BREAK looks like, or after the last slot.
module dmx_rx #(
    parameter int CLK_FREQ     = 12090000,
    parameter int BAUD_RATE    = 250000,
    parameter int BREAK_MIN_US = 88,
    parameter int MAX_SLOTS    = 512
) (
    input  logic     clk,
    input  logic     rst,
    input  logic     rx,
    input  logic     enable,
    dmx_rx_if.master bus
);
    localparam int BIT_TIME  = CLK_FREQ / BAUD_RATE;
    localparam int HALF_BIT  = BIT_TIME / 2;
    localparam int BREAK_MIN = (CLK_FREQ / 1000000) * BREAK_MIN_US;
    localparam int BRK_LOW   = 9 * BIT_TIME + HALF_BIT;
    localparam int CNT_MAX   = (BREAK_MIN > BRK_LOW) ? BREAK_MIN : BRK_LOW;
    localparam int CW        = $clog2(CNT_MAX + 1);

    typedef enum logic [2:0] {
        S_IDLE, S_BREAK, S_MAB, S_START, S_DATA, S_STOP, S_WAIT
    } state_t;

    state_t        state, state_n;
    logic [CW-1:0] cnt, cnt_n;
    logic [2:0]    bit_idx, bit_n;
    logic [7:0]    shreg, sh_n;
    logic [9:0]    slot_idx, slot_n;
    logic          pend, pend_n;
    logic          rx_m, rx_s;

    logic       wr_en_q, wr_en_n;
    logic [9:0] wr_addr_q, wr_addr_n;
    logic [7:0] wr_data_q, wr_data_n;
    logic [7:0] sc_q, sc_n;
    logic       fd_q, fd_n;
    logic [9:0] cnt_q, cnt_out_n;
    logic       fe_q, fe_n;

    logic tick_half, tick_bit, stop_tick;

    assign tick_half = (cnt == CW'(HALF_BIT - 1));
    assign tick_bit  = (cnt == CW'(BIT_TIME - 1));
    assign stop_tick = enable && (state == S_STOP) && tick_bit;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rx_m      <= 1'b1;
            rx_s      <= 1'b1;
            state     <= S_IDLE;
            cnt       <= '0;
            bit_idx   <= '0;
            shreg     <= '0;
            slot_idx  <= '0;
            pend      <= 1'b0;
            wr_en_q   <= 1'b0;
            wr_addr_q <= '0;
            wr_data_q <= '0;
            sc_q      <= '0;
            fd_q      <= 1'b0;
            cnt_q     <= '0;
            fe_q      <= 1'b0;
        end else begin
            rx_m      <= rx;
            rx_s      <= rx_m;
            state     <= state_n;
            cnt       <= cnt_n;
            bit_idx   <= bit_n;
            shreg     <= sh_n;
            slot_idx  <= slot_n;
            pend      <= pend_n;
            wr_en_q   <= wr_en_n;
            wr_addr_q <= wr_addr_n;
            wr_data_q <= wr_data_n;
            sc_q      <= sc_n;
            fd_q      <= fd_n;
            cnt_q     <= cnt_out_n;
            fe_q      <= fe_n;
        end
    end

    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        bit_n   = bit_idx;
        sh_n    = shreg;
        slot_n  = slot_idx;
        pend_n  = 1'b0;
        if (!enable) begin
            state_n = S_IDLE;
        end else begin
            unique case (state)
                S_IDLE: begin
                    if (!rx_s) begin
                        state_n = S_BREAK;
                        cnt_n   = '0;
                    end
                end
                S_BREAK: begin
                    if (rx_s)
                        state_n = (cnt >= CW'(BREAK_MIN)) ? S_MAB : S_IDLE;
                    else if (cnt < CW'(BREAK_MIN))
                        cnt_n = cnt + 1'b1;
                end
                S_MAB: begin
                    if (!rx_s) begin
                        state_n = S_START;
                        cnt_n   = '0;
                        slot_n  = '0;
                    end
                end
                S_START: begin
                    if (tick_half) begin
                        cnt_n = '0;
                        bit_n = '0;
                        if (!rx_s)
                            state_n = S_DATA;
                        else
                            state_n = (slot_idx == '0) ? S_MAB : S_WAIT;
                    end else begin
                        cnt_n = cnt + 1'b1;
                    end
                end
                S_DATA: begin
                    if (tick_bit) begin
                        cnt_n = '0;
                        sh_n  = {rx_s, shreg[7:1]};
                        bit_n = bit_idx + 3'd1;
                        if (bit_idx == 3'd7)
                            state_n = S_STOP;
                    end else begin
                        cnt_n = cnt + 1'b1;
                    end
                end
                S_STOP: begin
                    if (!tick_bit) begin
                        cnt_n = cnt + 1'b1;
                    end else if (rx_s) begin
                        slot_n = slot_idx + 10'd1;
                        if (slot_idx == 10'(MAX_SLOTS)) begin
                            state_n = S_IDLE;
                            pend_n  = 1'b1;
                        end else begin
                            state_n = S_WAIT;
                        end
                    end else begin
                        // Line has been low since the start bit edge.
                        state_n = S_BREAK;
                        cnt_n   = CW'(BRK_LOW);
                    end
                end
                S_WAIT: begin
                    if (!rx_s) begin
                        state_n = S_START;
                        cnt_n   = '0;
                    end
                end
                default: state_n = S_IDLE;
            endcase
        end
    end

    always_comb begin
        wr_en_n   = 1'b0;
        wr_addr_n = wr_addr_q;
        wr_data_n = wr_data_q;
        sc_n      = sc_q;
        fd_n      = 1'b0;
        cnt_out_n = cnt_q;
        fe_n      = 1'b0;
        if (enable && pend) begin
            fd_n      = 1'b1;
            cnt_out_n = '0;
        end
        if (stop_tick) begin
            if (rx_s) begin
                if (slot_idx == '0) begin
                    sc_n = shreg;
                end else begin
                    wr_en_n   = 1'b1;
                    wr_addr_n = slot_idx - 10'd1;
                    wr_data_n = shreg;
                end
            end else begin
                fe_n = 1'b1;
                if (slot_idx > 10'd1) begin
                    fd_n      = 1'b1;
                    cnt_out_n = slot_idx - 10'd1;
                end
            end
        end
    end

    assign bus.wr_en       = wr_en_q;
    assign bus.wr_addr     = wr_addr_q;
    assign bus.wr_data     = wr_data_q;
    assign bus.start_code  = sc_q;
    assign bus.frame_done  = fd_q;
    assign bus.slot_count  = cnt_q;
    assign bus.framing_err = fe_q;
    assign bus.busy        = (state != S_IDLE);
endmodule
